frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Ping-pong frame-buffer controller that sequences the camera DDR write adaptor and hands completed frames to a downstream frame consumer (accelerator/DMA reader).
- Two DDR frame buffers: buf0 (odd_even_flag=0) and buf1 (odd_even_flag=1). Each buffer has a tracked status.
- Grants the adaptor a write target, holds the start handshake for the whole frame, and collects the finish handshake.
- Publishes the newest complete frame to the consumer, drops stale frames when the consumer is slow, and flags stalled writes.

Parameters:
- TIMEOUT_CYCLES, 32'd50_000_000, W_BUSY cycles without a finish before abort.
- CNT_W, 16, width of frame_cnt and drop_cnt.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  allow new frame writes; sampled only in W_IDLE
- ddr_write_start  out  1  write enable to adaptor
- ddr_write_start_valid  out  1  start qualifier
- ddr_write_start_ready  in  1  adaptor accepts start
- odd_even_flag  out  1  target buffer index; stable from W_START until finish
- ddr_write_finish  in  1  frame-complete flag
- ddr_write_finish_valid  in  1  finish qualifier; single-cycle pulse
- ddr_write_finish_ready  out  1  controller accepts finish
- rd_valid  out  1  a complete frame is offered
- rd_buf  out  1  buffer index offered
- rd_ready  in  1  consumer takes the offered frame
- rd_done  in  1  single-cycle pulse: consumer released its buffer
- frame_cnt  out  CNT_W  frames completed; wraps at 2^CNT_W
- drop_cnt  out  CNT_W  full frames overwritten before being read; wraps
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0.
  - Both buffer status registers FREE.
  - last_wr=1, so the first frame targets buf0.
  - Timeout counter 0. Writer FSM in W_IDLE.
- Buffer status encoding: FREE 2'b00, FULL 2'b01, READING 2'b10, WRITING 2'b11.
- Writer FSM:
  - W_IDLE:
    - Start/valid/finish_ready are 0.
    - If enable=1, go to W_SEL.
  - W_SEL (1 cycle):
    - Target = ~last_wr if that buffer is FREE; else last_wr if FREE.
    - Else target = the FULL buffer that is not READING. Increment drop_cnt in this case.
    - The chosen buffer is set to WRITING; odd_even_flag=target; go to W_START.
    - If rd_valid&&rd_ready occurs in the same cycle, stay in W_SEL one more cycle and reselect using the updated status. The reader has priority.
  - W_START:
    - ddr_write_start=1, ddr_write_start_valid=1.
    - When ddr_write_start_ready=1, go to W_BUSY.
  - W_BUSY:
    - start/valid remain 1 for the entire frame, because the adaptor rechecks them before every burst.
    - ddr_write_finish_ready=1. The timeout counter increments each cycle.
    - On finish_valid&&finish_ready&&finish:
      - Target goes to FULL; last_wr<=target; frame_cnt++.
      - start/valid/finish_ready drop on the next cycle; counter clears; go to W_IDLE.
    - On finish_valid with finish=0: ignore and stay in W_BUSY.
    - On counter==TIMEOUT_CYCLES-1 with no finish:
      - err_timeout<=1; target goes to FREE; counter clears; go to W_IDLE.
      - frame_cnt is unchanged.
- At most one buffer is ever WRITING, and at most one is ever READING.
- Reader side (combinational from registered status):
  - rd_valid = (some buffer FULL) && (no buffer READING).
  - rd_buf = last_wr if status[last_wr]==FULL; else the other buffer.
  - On rd_valid&&rd_ready: status[rd_buf] goes to READING on the next edge.
  - On rd_done: the READING buffer goes to FREE.
  - rd_done with no READING buffer is ignored.
  - rd_done and writer finish in the same cycle update different buffers; both take effect.
- The writer never targets a READING buffer. The reader is never offered a WRITING buffer.
- Deasserting enable mid-frame has no effect until the frame ends. Deasserting enable while in W_START does not cancel the start.
- Asynchronous reset mid-frame returns everything to reset values immediately. The partial frame is discarded, and buffer statuses return to FREE.

Test Plan:
- Single frame:
  - Stimulus: enable=1, ready=1; finish pulse after 500 cycles.
  - Response: odd_even_flag=0 and start/valid high throughout; next cycle frame_cnt=1, rd_valid=1, rd_buf=0, start=0.
- Ping-pong:
  - Stimulus: consumer takes buf0 and holds it (no rd_done); second frame completes.
  - Response: second frame flag=1; rd_valid stays 0 until rd_done. Then rd_valid=1, rd_buf=1, and buf0 is FREE.
- Slow consumer:
  - Stimulus: rd_ready=0 for 3 frames.
  - Response: frames go to bufs 0, 1, 0 in that order; drop_cnt=1, frame_cnt=3, rd_buf=0 (newest).
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; no finish after start accepted.
  - Response: after 100 W_BUSY cycles err_timeout=1, start=0, buffer FREE, frame_cnt=0; the next frame reuses the same buffer.
- Collision:
  - Stimulus: rd_ready asserted in the same cycle as W_SEL with both buffers FULL.
  - Response: the reader gets last_wr; the writer stalls 1 cycle and then targets the other buffer; drop_cnt=1.
- Reset:
  - Stimulus: aresetn low for 2 cycles mid-W_BUSY.
  - Response: all outputs 0 immediately; after release the first frame targets buf0.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame-buffer controller: grants the camera DDR write adaptor a target buffer,
// tracks both buffer states and offers the newest complete frame to a downstream reader.
module frame_buffer_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  output logic             ddr_write_start,
  output logic             ddr_write_start_valid,
  input  logic             ddr_write_start_ready,
  output logic             odd_even_flag,
  input  logic             ddr_write_finish,
  input  logic             ddr_write_finish_valid,
  output logic             ddr_write_finish_ready,
  output logic             rd_valid,
  output logic             rd_buf,
  input  logic             rd_ready,
  input  logic             rd_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_timeout
);

  typedef enum logic [1:0] {FREE = 2'b00, FULL = 2'b01, READING = 2'b10, WRITING = 2'b11} buf_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'b00, W_SEL = 2'b01, W_START = 2'b10, W_BUSY = 2'b11} wr_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wr_state_t        state_r;
  buf_state_t       status_r [2];
  logic             last_wr_r;
  logic             target_r;
  logic             start_r;
  logic             finish_ready_r;
  logic             err_r;
  logic [31:0]      tmo_cnt_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic any_full_s;
  logic any_reading_s;
  logic reading_idx_s;
  logic rd_take_s;
  logic finish_s;
  logic nxt_s;
  logic sel_target_s;
  logic sel_drop_s;

  // Reader offer and writer target selection, all derived from registered status.
  always_comb begin
    any_full_s    = (status_r[0] == FULL) || (status_r[1] == FULL);
    any_reading_s = (status_r[0] == READING) || (status_r[1] == READING);
    reading_idx_s = (status_r[1] == READING);
    rd_valid      = any_full_s && !any_reading_s;
    rd_buf        = (status_r[last_wr_r] == FULL) ? last_wr_r : ~last_wr_r;
    rd_take_s     = rd_valid && rd_ready;
    finish_s      = ddr_write_finish_valid && finish_ready_r && ddr_write_finish;
    nxt_s         = ~last_wr_r;
    sel_target_s  = nxt_s;
    sel_drop_s    = 1'b0;
    // Prefer a free buffer; otherwise overwrite the older full frame, never a READING one.
    if (status_r[nxt_s] == FREE) begin
      sel_target_s = nxt_s;
      sel_drop_s   = 1'b0;
    end else if (status_r[last_wr_r] == FREE) begin
      sel_target_s = last_wr_r;
      sel_drop_s   = 1'b0;
    end else if (status_r[nxt_s] == FULL) begin
      sel_target_s = nxt_s;
      sel_drop_s   = 1'b1;
    end else begin
      sel_target_s = last_wr_r;
      sel_drop_s   = 1'b1;
    end
  end

  // Writer FSM, buffer status bookkeeping, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r        <= W_IDLE;
      status_r[0]    <= FREE;
      status_r[1]    <= FREE;
      last_wr_r      <= 1'b1;
      target_r       <= 1'b0;
      start_r        <= 1'b0;
      finish_ready_r <= 1'b0;
      err_r          <= 1'b0;
      tmo_cnt_r      <= 32'd0;
      frame_cnt_r    <= {CNT_W{1'b0}};
      drop_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      if (rd_take_s) begin
        status_r[rd_buf] <= READING;
      end
      if (rd_done && any_reading_s) begin
        status_r[reading_idx_s] <= FREE;
      end
      case (state_r)
        W_IDLE: begin
          if (enable) begin
            state_r <= W_SEL;
          end
        end
        W_SEL: begin
          // A reader accept this cycle wins; reselect next cycle on the updated status.
          if (!rd_take_s) begin
            status_r[sel_target_s] <= WRITING;
            target_r               <= sel_target_s;
            start_r                <= 1'b1;
            state_r                <= W_START;
            if (sel_drop_s) begin
              drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
          end
        end
        W_START: begin
          if (ddr_write_start_ready) begin
            finish_ready_r <= 1'b1;
            state_r        <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (finish_s) begin
            status_r[target_r] <= FULL;
            last_wr_r          <= target_r;
            frame_cnt_r        <= frame_cnt_r + CNT_ONE;
            start_r            <= 1'b0;
            finish_ready_r     <= 1'b0;
            tmo_cnt_r          <= 32'd0;
            state_r            <= W_IDLE;
          end else if (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1)) begin
            status_r[target_r] <= FREE;
            err_r              <= 1'b1;
            start_r            <= 1'b0;
            finish_ready_r     <= 1'b0;
            tmo_cnt_r          <= 32'd0;
            state_r            <= W_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r <= W_IDLE;
        end
      endcase
    end
  end

  assign ddr_write_start        = start_r;
  assign ddr_write_start_valid  = start_r;
  assign ddr_write_finish_ready = finish_ready_r;
  assign odd_even_flag          = target_r;
  assign frame_cnt              = frame_cnt_r;
  assign drop_cnt               = drop_cnt_r;
  assign err_timeout            = err_r;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: expected target buffers are queued as frames are
// requested and popped when the controller raises its start handshake.
module tb_frame_buffer_ctrl;

  localparam logic [31:0] T_CYC = 32'd1000;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        ddr_write_start;
  logic        ddr_write_start_valid;
  logic        ddr_write_start_ready;
  logic        odd_even_flag;
  logic        ddr_write_finish;
  logic        ddr_write_finish_valid;
  logic        ddr_write_finish_ready;
  logic        rd_valid;
  logic        rd_buf;
  logic        rd_ready;
  logic        rd_done;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        err_timeout;

  int   errors = 0;
  int   checks = 0;
  int   exp_frames = 0;
  logic exp_q[$];
  logic cur_flag;

  frame_buffer_ctrl #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(16)) dut (
    .clk                    (clk),
    .aresetn                (aresetn),
    .enable                 (enable),
    .ddr_write_start        (ddr_write_start),
    .ddr_write_start_valid  (ddr_write_start_valid),
    .ddr_write_start_ready  (ddr_write_start_ready),
    .odd_even_flag          (odd_even_flag),
    .ddr_write_finish       (ddr_write_finish),
    .ddr_write_finish_valid (ddr_write_finish_valid),
    .ddr_write_finish_ready (ddr_write_finish_ready),
    .rd_valid               (rd_valid),
    .rd_buf                 (rd_buf),
    .rd_ready               (rd_ready),
    .rd_done                (rd_done),
    .frame_cnt              (frame_cnt),
    .drop_cnt               (drop_cnt),
    .err_timeout            (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a frame and check the granted buffer against the queued expectation.
  task automatic start_frame(input logic exp_flag);
    exp_q.push_back(exp_flag);
    enable = 1'b1;
    ddr_write_start_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ddr_write_start === 1'b1) break;
      tick();
    end
    enable = 1'b0;
    chk("start_seen", {31'd0, ddr_write_start}, 32'd1);
    cur_flag = exp_q.pop_front();
    chk("target_flag", {31'd0, odd_even_flag}, {31'd0, cur_flag});
  endtask

  // Run the frame body, verify start/valid/flag hold, then complete it with a finish pulse.
  task automatic finish_frame(input int busy);
    int bad;
    bad = 0;
    tick();
    for (int i = 0; i < busy; i++) begin
      if (ddr_write_start !== 1'b1 || ddr_write_start_valid !== 1'b1 || odd_even_flag !== cur_flag) bad++;
      tick();
    end
    chk("hold_during_frame", bad, 32'd0);
    chk("finish_ready", {31'd0, ddr_write_finish_ready}, 32'd1);
    ddr_write_finish       = 1'b1;
    ddr_write_finish_valid = 1'b1;
    tick();
    ddr_write_finish       = 1'b0;
    ddr_write_finish_valid = 1'b0;
    exp_frames++;
    chk("frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("start_dropped", {31'd0, ddr_write_start}, 32'd0);
  endtask

  task automatic take_and_release();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rd_done  = 1'b1;
    tick();
    rd_done  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; enable = 1'b0; ddr_write_start_ready = 1'b0;
    ddr_write_finish = 1'b0; ddr_write_finish_valid = 1'b0; rd_ready = 1'b0; rd_done = 1'b0;
    tick(); tick();
    chk("rst_start", {31'd0, ddr_write_start}, 32'd0);
    chk("rst_flag", {31'd0, odd_even_flag}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_buf", {31'd0, rd_buf}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    aresetn = 1'b1;
    tick();

    // Single long frame into buf0.
    start_frame(1'b0);
    finish_frame(500);
    chk("single_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("single_rd_buf", {31'd0, rd_buf}, 32'd0);

    // Ping-pong: consumer holds buf0 while buf1 fills.
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("pp_rd_valid_held", {31'd0, rd_valid}, 32'd0);
    start_frame(1'b1);
    finish_frame(20);
    chk("pp_rd_valid_wait", {31'd0, rd_valid}, 32'd0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("pp_rd_valid_after_done", {31'd0, rd_valid}, 32'd1);
    chk("pp_rd_buf", {31'd0, rd_buf}, 32'd1);
    take_and_release();
    chk("pp_all_free", {31'd0, rd_valid}, 32'd0);

    // Slow consumer: three frames, the third overwrites the older full buffer.
    start_frame(1'b0); finish_frame(10);
    start_frame(1'b1); finish_frame(10);
    start_frame(1'b0); finish_frame(10);
    chk("slow_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    chk("slow_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("slow_rd_buf", {31'd0, rd_buf}, 32'd0);

    // Collision: reader accepts during W_SEL with both buffers full.
    enable = 1'b1; tick();
    chk("col_offer_last_wr", {31'd0, rd_buf}, 32'd0);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0; enable = 1'b0;
    chk("col_writer_stall", {31'd0, ddr_write_start}, 32'd0);
    chk("col_reader_took", {31'd0, rd_valid}, 32'd0);
    start_frame(1'b1);
    chk("col_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    finish_frame(10);
    chk("col_rd_valid_busy", {31'd0, rd_valid}, 32'd0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("col_rd_buf", {31'd0, rd_buf}, 32'd1);
    take_and_release();

    // Timeout: no finish for exactly T_CYC busy cycles.
    start_frame(1'b0);
    tick();
    for (int i = 0; i < int'(T_CYC) - 1; i++) tick();
    chk("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
    chk("tmo_start_still", {31'd0, ddr_write_start}, 32'd1);
    tick();
    chk("tmo_err", {31'd0, err_timeout}, 32'd1);
    chk("tmo_start_low", {31'd0, ddr_write_start}, 32'd0);
    chk("tmo_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("tmo_buf_free", {31'd0, rd_valid}, 32'd0);
    start_frame(1'b0);
    finish_frame(10);
    chk("tmo_sticky", {31'd0, err_timeout}, 32'd1);

    // Asynchronous reset in the middle of a frame.
    start_frame(1'b1);
    tick(); tick(); tick();
    aresetn = 1'b0;
    #1;
    chk("arst_start", {31'd0, ddr_write_start}, 32'd0);
    chk("arst_finish_ready", {31'd0, ddr_write_finish_ready}, 32'd0);
    chk("arst_flag", {31'd0, odd_even_flag}, 32'd0);
    chk("arst_err", {31'd0, err_timeout}, 32'd0);
    chk("arst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("arst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    exp_frames = 0;
    tick();
    start_frame(1'b0);
    finish_frame(10);
    chk("post_rst_rd_buf", {31'd0, rd_buf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
